// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 mux: picks one requester, drives
// the mux select and a one-hot grant, and releases on done, request drop or hold limit.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic             done,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_MAX - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] pick_idx;
    logic       rel;

    // First requester at or after ptr, wrapping 3 -> 0; caller checks req != 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] found_idx;
        logic       found;
        found     = 1'b0;
        found_idx = p;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (r[idx] && !found) begin
                found     = 1'b1;
                found_idx = idx;
            end
        end
        return found_idx;
    endfunction

    always_comb begin
        pick_idx = rr_pick(req, ptr);
        rel      = done | ~req[sel] | (hold_cnt == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 2'b00;
            grant    <= 4'b0000;
            busy     <= 1'b0;
            hold_cnt <= '0;
            ptr      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        sel      <= pick_idx;
                        grant    <= 4'b0001 << pick_idx;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    // Any mix of release causes collapses into one release and one ptr step.
                    if (rel) begin
                        state    <= IDLE;
                        grant    <= 4'b0000;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        ptr      <= sel + 2'd1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_busy   : assert property (@(posedge clk) disable iff (!rst_n) ((grant != 4'b0000) == busy));
    a_sel    : assert property (@(posedge clk) disable iff (!rst_n) (busy -> (grant == (4'b0001 << sel))));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model, for HOLD_MAX=4 and HOLD_MAX=1 instances.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;

    logic [1:0] sel0, sel1;
    logic [3:0] grant0, grant1;
    logic       busy0, busy1;
    logic [2:0] cnt0;
    logic [1:0] cnt1;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state per instance: owner is -1 while idle.
    int m_owner [2];
    int m_sel   [2];
    int m_ptr   [2];
    int m_cnt   [2];
    int m_hold  [2];

    mux4_rr_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel0), .grant(grant0), .busy(busy0), .hold_cnt(cnt0)
    );

    mux4_rr_arbiter #(.HOLD_MAX(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel1), .grant(grant1), .busy(busy1), .hold_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_edge(input int i);
        if (!rst_n) begin
            m_owner[i] = -1;
            m_sel[i]   = 0;
            m_ptr[i]   = 0;
            m_cnt[i]   = 0;
        end else if (m_owner[i] < 0) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr[i] + k) % 4;
                if (req[c] && m_owner[i] < 0) begin
                    m_owner[i] = c;
                    m_sel[i]   = c;
                    m_cnt[i]   = 0;
                end
            end
        end else if (done || !req[m_owner[i]] || (m_cnt[i] + 1 >= m_hold[i])) begin
            m_ptr[i]   = (m_owner[i] + 1) % 4;
            m_owner[i] = -1;
            m_cnt[i]   = 0;
        end else begin
            m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    function automatic logic [3:0] m_grant(input int i);
        return (m_owner[i] < 0) ? 4'b0000 : 4'(1 << m_owner[i]);
    endfunction

    task automatic cycle(input logic [3:0] r, input logic d, input logic rn);
        req   = r;
        done  = d;
        rst_n = rn;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("grant0", 32'(grant0), 32'(m_grant(0)));
        check("sel0",   32'(sel0),   32'(m_sel[0]));
        check("busy0",  32'(busy0),  32'(m_owner[0] >= 0));
        check("cnt0",   32'(cnt0),   32'(m_cnt[0]));
        check("grant1", 32'(grant1), 32'(m_grant(1)));
        check("sel1",   32'(sel1),   32'(m_sel[1]));
        check("busy1",  32'(busy1),  32'(m_owner[1] >= 0));
        check("cnt1",   32'(cnt1),   32'(m_cnt[1]));
    endtask

    initial begin
        m_hold[0] = 4;
        m_hold[1] = 1;
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1; m_sel[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
        end
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;

        // Reset with all requests active
        for (int n = 0; n < 2; n++) begin
            cycle(4'b1111, 1'b0, 1'b0);
            check("rst_grant", 32'(grant0), 32'h0);
            check("rst_sel",   32'(sel0),   32'h0);
            check("rst_busy",  32'(busy0),  32'h0);
            check("rst_cnt",   32'(cnt0),   32'h0);
        end

        // Single request, done pulse, then wrap scan from ptr=3
        cycle(4'b0100, 1'b0, 1'b1);
        check("single_grant", 32'(grant0), 32'h4);
        check("single_sel",   32'(sel0),   32'h2);
        check("single_busy",  32'(busy0),  32'h1);
        cycle(4'b0100, 1'b1, 1'b1);
        check("done_release", 32'(grant0), 32'h0);
        cycle(4'b0001, 1'b0, 1'b1);
        check("wrap_grant", 32'(grant0), 32'h1);
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        check("idle_sel_hold", 32'(sel0), 32'h0);

        // Fairness and timeout
        cycle(4'b1111, 1'b0, 1'b0);
        for (int j = 0; j < 40; j++) begin
            int pos, grp;
            pos = j % 5;
            grp = (j / 5) % 4;
            cycle(4'b1111, 1'b0, 1'b1);
            check("rr_grant", 32'(grant0), (pos < 4) ? 32'(1 << grp) : 32'h0);
            check("rr_cnt",   32'(cnt0),   (pos < 4) ? 32'(pos) : 32'h0);
        end

        // Request drop by owner
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b1);
        check("drop_pre_cnt", 32'(cnt0), 32'h1);
        cycle(4'b1100, 1'b0, 1'b1);
        check("drop_grant", 32'(grant0), 32'h0);
        check("drop_busy",  32'(busy0),  32'h0);
        cycle(4'b1110, 1'b0, 1'b1);
        check("drop_next", 32'(grant0), 32'h4);

        // Coincident done and timeout
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0001, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) cycle(4'b1111, 1'b0, 1'b1);
        check("coinc_cnt", 32'(cnt0), 32'h3);
        cycle(4'b1111, 1'b1, 1'b1);
        check("coinc_rel", 32'(grant0), 32'h0);
        cycle(4'b1111, 1'b0, 1'b1);
        check("coinc_next", 32'(grant0), 32'h2);

        // Reset mid-grant
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b1000, 1'b0, 1'b1);
        cycle(4'b1000, 1'b0, 1'b1);
        cycle(4'b1000, 1'b0, 1'b1);
        check("mid_pre_cnt", 32'(cnt0), 32'h2);
        cycle(4'b1111, 1'b0, 1'b0);
        check("mid_grant", 32'(grant0), 32'h0);
        check("mid_sel",   32'(sel0),   32'h0);
        check("mid_cnt",   32'(cnt0),   32'h0);
        cycle(4'b1111, 1'b0, 1'b1);
        check("mid_next", 32'(grant0), 32'h1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] r;
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'b1111;
            cycle(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 49) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
